pulse_gen_multi: RTL and testbench
==================================

PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent pulse channels (1..16).
REQ-002 Parameter CNT_W, default 32: width of each channel counter, period and high-length register.
REQ-003 Parameter CH_W, default 2: channel-select width; SHALL be >= clog2(NUM_CH).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 cfg_we  in  1  config write strobe, one write per asserted cycle.
REQ-007 cfg_ch  in  CH_W  target channel of the write.
REQ-008 cfg_sel  in  2  target register: 0=period, 1=high_len, 2=control, 3=reserved.
REQ-009 cfg_wdata  in  CNT_W  write data; control uses bit0=enable, bit1=one_shot, other bits ignored.
REQ-010 pulse_out  out  NUM_CH  per-channel pulse waveform.
REQ-011 tick_out  out  NUM_CH  per-channel one-cycle strobe at the start of each period.
REQ-012 busy  out  NUM_CH  per-channel running flag.

Function
REQ-013 Each channel SHALL hold period P, high_len H, one_shot OS, running flag R and counter C, all CNT_W wide except the 1-bit flags.
REQ-014 All outputs SHALL be decoded from registered state only: no combinational path from any input to any output.
REQ-015 pulse_out[i] SHALL be R && (C < H); tick_out[i] SHALL be R && (C == 0); busy[i] SHALL be R.
REQ-016 While R=1, C SHALL increment by 1 each cycle; when C >= P, C SHALL load 0 on the next edge.
REQ-017 The effective period SHALL therefore be P+1 cycles.
REQ-018 P=0 SHALL give tick_out high every running cycle.
REQ-019 H=0 SHALL keep pulse_out low.
REQ-020 H > P SHALL keep pulse_out high for the whole running interval.
REQ-021 Writing control with enable=1 SHALL, on the next edge, set R=1, C=0 and latch OS. This applies whether the channel was stopped or running, so a running channel restarts.
REQ-022 Writing control with enable=0 SHALL, on the next edge, set R=0 and C=0.
REQ-023 Periodic mode (OS=0): the wrap at C >= P SHALL repeat indefinitely.
REQ-024 One-shot mode (OS=1): on the edge where C >= P, the channel SHALL set R=0 and C=0 instead of wrapping, giving exactly one period of output.
REQ-025 Writes to period or high_len SHALL take effect on the next edge and SHALL NOT reset C. If the new P < C, the channel SHALL wrap on the next edge per REQ-016.
REQ-026 While R=0, C SHALL hold 0.
REQ-027 Writes with cfg_ch >= NUM_CH or cfg_sel=3 SHALL be ignored with no state change.
REQ-028 A control write to channel i SHALL take priority over channel i's own one-shot termination or wrap in the same cycle.
REQ-029 Channels SHALL be fully independent; a write SHALL affect only channel cfg_ch.
REQ-030 Counter arithmetic SHALL be unsigned modulo 2^CNT_W.

Reset
REQ-031 rst_n=0 at a rising edge SHALL clear P, H, OS, R and C of every channel to 0, so pulse_out, tick_out and busy read all-zero the following cycle.
REQ-032 Reset SHALL override any concurrent cfg_we in the same cycle.
REQ-033 Reset asserted mid-period SHALL abort the channel immediately, with no further tick or pulse.
REQ-034 After reset deassertion, channels SHALL remain idle until a control write with enable=1.

Verification
REQ-035 Periodic mode: ch0 P=7, H=3, control=1 -> tick_out[0] one cycle every 8, pulse_out[0] high 3 of every 8 cycles, first tick the cycle after the control write.
REQ-036 One-shot mode: ch1 P=4, H=2, control=3 -> busy[1] high for exactly 5 cycles, one tick, pulse high 2 cycles, then all ch1 outputs 0 and stay 0.
REQ-037 Degenerate P and H: P=0, H=1 -> tick_out and pulse_out constantly 1 while enabled; H=0 -> pulse_out constantly 0; H=10, P=5 -> pulse_out constantly 1.
REQ-038 Live period shrink: ch2 running with P=20 reaches C=12; write P=5 -> C=0 on the next edge, then a 6-cycle period.
REQ-039 Restart, disable and invalid writes: control=1 to a running channel at C=3 -> tick next cycle. control=0 -> all outputs 0 next cycle. cfg_sel=3 or cfg_ch=NUM_CH -> no change on any channel.
REQ-040 Reset mid-operation: rst_n low during an active pulse with a concurrent cfg_we -> all outputs 0 next cycle and stay 0 until re-enabled; P and H read back as 0 via behaviour (enable alone gives tick every cycle, no pulse).

Source files
------------

// File: rtl/pulse_gen_multi.sv
// Multi-channel programmable pulse generator: each channel runs a wrapping
// counter that produces a tick at the start of every period and a pulse for high_len cycles.
module pulse_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [CNT_W-1:0]  cfg_wdata,
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] busy
);

  typedef enum logic [1:0] {
    SEL_PERIOD = 2'd0,
    SEL_HIGH   = 2'd1,
    SEL_CTRL   = 2'd2,
    SEL_RSVD   = 2'd3
  } sel_e;

  logic [CNT_W-1:0]  r_period [NUM_CH];
  logic [CNT_W-1:0]  r_high   [NUM_CH];
  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [NUM_CH-1:0] r_oneShot;
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] w_wrCh;

  // Out-of-range channel numbers match no channel, so such writes fall away.
  always_comb begin
    w_wrCh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wrCh[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_period[i]  <= '0;
        r_high[i]    <= '0;
        r_cnt[i]     <= '0;
        r_oneShot[i] <= 1'b0;
        r_run[i]     <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wrCh[i] && (cfg_sel == SEL_PERIOD)) begin
          r_period[i] <= cfg_wdata;
        end
        if (w_wrCh[i] && (cfg_sel == SEL_HIGH)) begin
          r_high[i] <= cfg_wdata;
        end
        // A control write wins over this cycle's wrap or one-shot stop.
        if (w_wrCh[i] && (cfg_sel == SEL_CTRL)) begin
          r_run[i] <= cfg_wdata[0];
          r_cnt[i] <= '0;
          if (cfg_wdata[0]) begin
            r_oneShot[i] <= cfg_wdata[1];
          end
        end else if (r_run[i]) begin
          if (r_cnt[i] >= r_period[i]) begin
            r_cnt[i] <= '0;
            if (r_oneShot[i]) begin
              r_run[i] <= 1'b0;
            end
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    pulse_out = '0;
    tick_out  = '0;
    busy      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pulse_out[i] = r_run[i] && (r_cnt[i] < r_high[i]);
      tick_out[i]  = r_run[i] && (r_cnt[i] == '0);
      busy[i]      = r_run[i];
    end
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: a vector table for periodic/restart/invalid
// writes, then hand sequences for one-shot, degenerate P/H, live shrink and reset.
module tb_pulse_gen_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;

  logic              clk;
  logic              rst_n;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_sel;
  logic [CNT_W-1:0]  cfg_wdata;
  logic [NUM_CH-1:0] pulse_out;
  logic [NUM_CH-1:0] tick_out;
  logic [NUM_CH-1:0] busy;

  int checkCount;
  int errorCount;

  typedef struct {
    logic        rstN;
    logic        we;
    logic [1:0]  ch;
    logic [1:0]  sel;
    logic [15:0] wdata;
    logic [2:0]  expPulse;
    logic [2:0]  expTick;
    logic [2:0]  expBusy;
  } vec_t;

  vec_t vecs [20];

  pulse_gen_multi #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W),
    .CH_W  (CH_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_wdata(cfg_wdata),
    .pulse_out(pulse_out),
    .tick_out (tick_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rstN, input logic we, input logic [1:0] ch,
                               input logic [1:0] sel, input logic [15:0] wdata);
    rst_n     = rstN;
    cfg_we    = we;
    cfg_ch    = ch;
    cfg_sel   = sel;
    cfg_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 16'd0);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] eP,
                             input logic [2:0] eT, input logic [2:0] eB);
    checkCount++;
    if ({pulse_out, tick_out, busy} !== {eP, eT, eB}) begin
      errorCount++;
      $display("[TB] FAIL %s got pulse=%b tick=%b busy=%b expected pulse=%b tick=%b busy=%b",
               name, pulse_out, tick_out, busy, eP, eT, eB);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_wdata = '0;

    // ch0 periodic P=7 H=3, invalid writes mid-run, restart at C=3, disable
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000};
    vecs[2]  = '{1'b1, 1'b1, 2'd0, 2'd0, 16'd7, 3'b000, 3'b000, 3'b000};
    vecs[3]  = '{1'b1, 1'b1, 2'd0, 2'd1, 16'd3, 3'b000, 3'b000, 3'b000};
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 2'd2, 16'd1, 3'b001, 3'b001, 3'b001};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b001, 3'b000, 3'b001};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b001, 3'b000, 3'b001};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b001};
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 2'd3, 16'd0, 3'b000, 3'b000, 3'b001};
    vecs[9]  = '{1'b1, 1'b1, 2'd3, 2'd2, 16'd0, 3'b000, 3'b000, 3'b001};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b001};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b001};
    vecs[12] = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b001, 3'b001, 3'b001};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b001, 3'b000, 3'b001};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b001, 3'b000, 3'b001};
    vecs[15] = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b001};
    vecs[16] = '{1'b1, 1'b1, 2'd0, 2'd2, 16'd1, 3'b001, 3'b001, 3'b001};
    vecs[17] = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b001, 3'b000, 3'b001};
    vecs[18] = '{1'b1, 1'b1, 2'd0, 2'd2, 16'd0, 3'b000, 3'b000, 3'b000};
    vecs[19] = '{1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000};

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].we, vecs[i].ch, vecs[i].sel, vecs[i].wdata);
      checkOutput($sformatf("vec%0d", i), vecs[i].expPulse, vecs[i].expTick, vecs[i].expBusy);
    end

    // ch1 one-shot P=4 H=2: busy for C=0..4, pulse for C=0..1, then silent
    applyStimulus(1'b1, 1'b1, 2'd1, 2'd0, 16'd4);
    applyStimulus(1'b1, 1'b1, 2'd1, 2'd1, 16'd2);
    applyStimulus(1'b1, 1'b1, 2'd1, 2'd2, 16'd3);
    checkOutput("oneshot_c0", 3'b010, 3'b010, 3'b010);
    for (int k = 1; k < 9; k++) begin
      idle();
      checkOutput($sformatf("oneshot_k%0d", k),
                  (k < 2) ? 3'b010 : 3'b000, 3'b000, (k < 5) ? 3'b010 : 3'b000);
    end

    // ch2 degenerate: P=0 H=1, then H=0, then P=5 H=10
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd1, 16'd1);
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd2, 16'd1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) idle();
      checkOutput($sformatf("p0h1_%0d", k), 3'b100, 3'b100, 3'b100);
    end
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd1, 16'd0);
    checkOutput("p0h0_a", 3'b000, 3'b100, 3'b100);
    idle();
    checkOutput("p0h0_b", 3'b000, 3'b100, 3'b100);
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd0, 16'd5);
    checkOutput("p5h0", 3'b000, 3'b100, 3'b100);
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd1, 16'd10);
    checkOutput("p5h10_c1", 3'b100, 3'b000, 3'b100);
    for (int k = 2; k < 8; k++) begin
      idle();
      checkOutput($sformatf("p5h10_k%0d", k), 3'b100, ((k % 6) == 0) ? 3'b100 : 3'b000, 3'b100);
    end

    // ch2 live shrink: P=20 H=10, run to C=11, write P=5 so the edge lands C=12
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd2, 16'd0);
    checkOutput("shrink_off", 3'b000, 3'b000, 3'b000);
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd0, 16'd20);
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd2, 16'd1);
    checkOutput("shrink_c0", 3'b100, 3'b100, 3'b100);
    for (int k = 1; k < 12; k++) begin
      idle();
      checkOutput($sformatf("shrink_c%0d", k), (k < 10) ? 3'b100 : 3'b000, 3'b000, 3'b100);
    end
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd0, 16'd5);
    checkOutput("shrink_c12", 3'b000, 3'b000, 3'b100);
    for (int k = 0; k < 13; k++) begin
      idle();
      checkOutput($sformatf("shrink_wrap%0d", k), 3'b100, ((k % 6) == 0) ? 3'b100 : 3'b000, 3'b100);
    end

    // Reset mid-pulse on ch0 with a concurrent enable write to ch1
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd2, 16'd0);
    checkOutput("rst_pre_off", 3'b000, 3'b000, 3'b000);
    applyStimulus(1'b1, 1'b1, 2'd0, 2'd2, 16'd1);
    checkOutput("rst_pre_c0", 3'b001, 3'b001, 3'b001);
    idle();
    checkOutput("rst_pre_c1", 3'b001, 3'b000, 3'b001);
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd2, 16'd1);
    checkOutput("rst_now", 3'b000, 3'b000, 3'b000);
    for (int k = 0; k < 3; k++) begin
      idle();
      checkOutput($sformatf("rst_idle%0d", k), 3'b000, 3'b000, 3'b000);
    end
    applyStimulus(1'b1, 1'b1, 2'd0, 2'd2, 16'd1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) idle();
      checkOutput($sformatf("rst_cleared%0d", k), 3'b000, 3'b001, 3'b001);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
